// File: rtl/contador_pkg.sv
// ---------------------------------------------------------------------------
// contador_pkg
// Shared constants and helpers for the programmable counter family.
//   DEFAULT_WIDTH   : default counter width in bits
//   DEFAULT_PRESC_W : default prescaler ratio width in bits
//   defaultMaxVal() : all-ones terminal value for a given counter width
// Optional feature macro used by the family: CONTADOR_PRESC_EN
// ---------------------------------------------------------------------------
package contador_pkg;

    localparam int DEFAULT_WIDTH   = 32;
    localparam int DEFAULT_PRESC_W = 8;

    // Largest value representable in w bits. The result is computed in 64 bits
    // so that w = 32 does not overflow.
    function automatic logic [63:0] defaultMaxVal(input int unsigned w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage : contador_pkg

// File: rtl/contador_presc.sv
// ---------------------------------------------------------------------------
// contador_presc
// Runtime-programmable rate divider for contador_prog. It counts enabled clock
// cycles from 0 up to presc, and asserts tick on the cycle whose count equals
// presc. On that cycle the count returns to 0, so the spacing between ticks is
// presc+1 enabled cycles.
// Ports:
//   clk     in  rising-edge clock
//   reset_n in  asynchronous active-low reset
//   clr     in  synchronous restart of the divider (driven by clear or load)
//   en      in  count enable; the divider holds its count while low
//   presc   in  ratio minus one
//   tick    out high on the cycle the count matches presc
// Only instantiated when CONTADOR_PRESC_EN is defined.
// ---------------------------------------------------------------------------
module contador_presc
    import contador_pkg::*;
#(
    parameter int PRESC_W = DEFAULT_PRESC_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clr,
    input  logic               en,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    localparam logic [PRESC_W-1:0] PrescZero = '0;
    localparam logic [PRESC_W-1:0] PrescOne  = {{(PRESC_W-1){1'b0}}, 1'b1};

    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;
    logic               match;

    // The compare is exact equality, so a count already above a newly written
    // ratio keeps incrementing and wraps naturally before it can match again.
    assign match = (presc_q == presc);
    assign tick  = match;

    // Next-state: restart on clear, otherwise advance only on enabled cycles.
    always_comb begin
        presc_d = presc_q;
        if (clr) begin
            presc_d = PrescZero;
        end else if (en) begin
            if (match) begin
                presc_d = PrescZero;
            end else begin
                presc_d = presc_q + PrescOne;
            end
        end
    end

    // Divider count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= PrescZero;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule : contador_presc

// File: rtl/contador_prog.sv
// ---------------------------------------------------------------------------
// contador_prog
// Parametrised registered up/down counter with synchronous clear, parallel
// load (clamped to the terminal value), programmable terminal value MAX_VAL
// and a one-cycle terminal-count pulse on every wrap.
// Parameters:
//   WIDTH   counter width (2..32)
//   MAX_VAL terminal value; the count runs 0..MAX_VAL and wraps
//   PRESC_W prescaler ratio width (meaningful with CONTADOR_PRESC_EN)
// Ports:
//   clk     in  rising-edge clock
//   reset_n in  asynchronous active-low reset
//   clr     in  synchronous clear (highest priority)
//   load    in  synchronous load of din (clamped to MAX_VAL)
//   din     in  load value
//   en      in  count enable
//   up      in  1 = increment, 0 = decrement
//   presc   in  prescaler ratio minus one (only with CONTADOR_PRESC_EN)
//   y       out registered count
//   tc      out registered terminal-count pulse, coincident with the wrap
// Optional feature macro: CONTADOR_PRESC_EN adds the presc port and a
// prescaler; without it the counter steps on every enabled cycle.
// ---------------------------------------------------------------------------
module contador_prog
    import contador_pkg::*;
#(
    parameter int          WIDTH   = DEFAULT_WIDTH,
    parameter logic [63:0] MAX_VAL = defaultMaxVal(WIDTH),
    parameter int          PRESC_W = DEFAULT_PRESC_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clr,
    input  logic               load,
    input  logic [WIDTH-1:0]   din,
    input  logic               en,
    input  logic               up,
`ifdef CONTADOR_PRESC_EN
    input  logic [PRESC_W-1:0] presc,
`endif
    output logic [WIDTH-1:0]   y,
    output logic               tc
);

    // Reject configurations the datapath cannot represent.
    if (WIDTH < 2 || WIDTH > 32) begin : gBadWidth
        $error("contador_prog: WIDTH must be in 2..32");
    end
    if (MAX_VAL > defaultMaxVal(WIDTH)) begin : gBadMaxVal
        $error("contador_prog: MAX_VAL does not fit in WIDTH bits");
    end
    if (PRESC_W < 1) begin : gBadPrescW
        $error("contador_prog: PRESC_W must be at least 1");
    end

    localparam logic [WIDTH-1:0] MaxV  = MAX_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] Zero  = '0;
    localparam logic [WIDTH-1:0] One   = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_q;
    logic             tc_d;
    logic             tick;
    logic [WIDTH-1:0] clampedDin;

`ifdef CONTADOR_PRESC_EN
    // The prescaler restarts whenever the count is forced, so a clear or load
    // always begins a fresh full spacing before the next step.
    contador_presc #(
        .PRESC_W (PRESC_W)
    ) uPresc (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr | load),
        .en      (en),
        .presc   (presc),
        .tick    (tick)
    );
`else
    assign tick = 1'b1;
`endif

    // Values above the terminal value saturate instead of wrapping.
    assign clampedDin = (din > MaxV) ? MaxV : din;

    // Next-state: clear beats load beats count beats hold. The terminal pulse
    // is produced only by a counting wrap and drops on every other edge.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (clr) begin
            count_d = Zero;
        end else if (load) begin
            count_d = clampedDin;
        end else if (en && tick) begin
            if (up) begin
                if (count_q == MaxV) begin
                    count_d = Zero;
                    tc_d    = 1'b1;
                end else begin
                    count_d = count_q + One;
                end
            end else begin
                if (count_q == Zero) begin
                    count_d = MaxV;
                    tc_d    = 1'b1;
                end else begin
                    count_d = count_q - One;
                end
            end
        end
    end

    // Count and terminal-pulse registers; outputs come straight from here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= Zero;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign y  = count_q;
    assign tc = tc_q;

endmodule : contador_prog

// File: tb/tb_contador_prog.sv
// ---------------------------------------------------------------------------
// tb_contador_prog
// Directed bench for contador_prog configured as a decade counter
// (WIDTH=4, MAX_VAL=9). Prescaler vectors are included when
// CONTADOR_PRESC_EN is defined.
// ---------------------------------------------------------------------------
module tb_contador_prog;

    localparam int WIDTH   = 4;
    localparam int PRESC_W = 8;

    logic             clk;
    logic             reset_n;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] din;
    logic             en;
    logic             up;
`ifdef CONTADOR_PRESC_EN
    logic [PRESC_W-1:0] presc;
`endif
    logic [WIDTH-1:0] y;
    logic             tc;

    int checkCount;
    int errorCount;

    contador_prog #(
        .WIDTH   (WIDTH),
        .MAX_VAL (64'd9),
        .PRESC_W (PRESC_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr),
        .load    (load),
        .din     (din),
        .en      (en),
        .up      (up),
`ifdef CONTADOR_PRESC_EN
        .presc   (presc),
`endif
        .y       (y),
        .tc      (tc)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one set of inputs, let one rising edge take them, settle 1 unit.
    task automatic applyStimulus(input logic c, input logic l, input logic [WIDTH-1:0] d,
                                 input logic e, input logic u);
        clr  = c;
        load = l;
        din  = d;
        en   = e;
        up   = u;
        @(posedge clk);
        #1;
    endtask

    // Check both outputs after a step.
    task automatic checkYTc(input string tag, input int expY, input logic expTc);
        checkOutput({tag, ".y"}, 32'(y), 32'(expY));
        checkOutput({tag, ".tc"}, 32'(tc), 32'(expTc));
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        reset_n = 1'b0;
        clr = 1'b0; load = 1'b0; din = '0; en = 1'b0; up = 1'b1;
`ifdef CONTADOR_PRESC_EN
        presc = '0;
`endif
        @(posedge clk);
        #1;
        checkYTc("reset", 0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;

        // Decade wrap upwards: 1..9, then 0 with a single tc cycle.
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
            checkYTc($sformatf("up%0d", i), i, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        checkYTc("upWrap", 0, 1'b1);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        checkYTc("upAfterWrap", 1, 1'b0);

        // Asynchronous reset mid-count at y=5.
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        checkYTc("preReset", 5, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        checkYTc("asyncReset", 0, 1'b0);
        #1;
        reset_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        checkYTc("resume1", 1, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        checkYTc("resume2", 2, 1'b0);

        // Downward wrap from a loaded zero.
        applyStimulus(1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
        checkYTc("load0", 0, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        checkYTc("downWrap", 9, 1'b1);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        checkYTc("down8", 8, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        checkYTc("down7", 7, 1'b0);

        // Priority and clamping.
        applyStimulus(1'b1, 1'b1, 4'd7, 1'b1, 1'b1);
        checkYTc("clrOverLoad", 0, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'd15, 1'b1, 1'b1);
        checkYTc("loadClamp", 9, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        checkYTc("wrapFromClamp", 0, 1'b1);
        applyStimulus(1'b0, 1'b1, 4'd9, 1'b1, 1'b1);
        checkYTc("loadMax", 9, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
        checkYTc("clrOverCount", 0, 1'b0);

        // Enable gating and direction flip around y=4.
        applyStimulus(1'b0, 1'b1, 4'd4, 1'b0, 1'b1);
        checkYTc("load4", 4, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        checkYTc("step5", 5, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        checkYTc("hold5", 5, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        checkYTc("back4", 4, 1'b0);

`ifdef CONTADOR_PRESC_EN
        // Prescaler ratio 3: steps land on enabled cycles 3, 6 and 9.
        presc = 8'd2;
        applyStimulus(1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
        checkYTc("prescLoad0", 0, 1'b0);
        begin
            int expSeq[9] = '{0, 0, 1, 1, 1, 2, 2, 2, 3};
            for (int i = 0; i < 9; i++) begin
                applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
                checkYTc($sformatf("presc%0d", i + 1), expSeq[i], 1'b0);
            end
        end
        // Two cycles into the next spacing, a load restarts the full spacing.
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 4'd5, 1'b1, 1'b1);
        checkYTc("prescMidLoad", 5, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        checkYTc("prescRestart1", 5, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        checkYTc("prescHold", 5, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        checkYTc("prescRestart2", 5, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        checkYTc("prescRestart3", 6, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule : tb_contador_prog
